// File: rtl/line_memory_responder.sv
// line_memory_responder: single-port 256-bit line memory with a fixed
// request-to-acknowledge latency.
//
// Handshake: a request is taken when enable_i is high at a rising edge while
// the block is idle; addr_i/data_i/write_i are captured at that edge and all
// inputs are ignored until the acknowledge. ack_o is high for exactly one
// cycle, the LATENCY-th cycle after the sampling edge. data_o is valid
// whenever ack_o is high and holds its value until the next read completes.
//
// Optional feature: define MEM_RANGE_CHECK_EN to add err_o and reject
// addresses that have any bit set above the line index, instead of letting
// them alias onto the array.
module line_memory_responder #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o,
`ifdef MEM_RANGE_CHECK_EN
    output logic         err_o,
`endif
    output logic [1:0]   dbg_state_o
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_count;
    logic [IDX_W-1:0]   r_idx;
    logic [255:0]       r_data;
    logic               r_write;
    logic               r_oor;
    logic [255:0]       r_data_o;
    logic               r_err;
    logic               w_req_oor;
    logic               w_done;
    logic               w_mem_we;
    logic               w_unused_bits;

    // Line storage; deliberately not reset so it can be preloaded and survive resets.
    logic [255:0] memory [0:DEPTH-1];

`ifdef MEM_RANGE_CHECK_EN
    // Any address bit above the line index marks the request out of range.
    assign w_req_oor = |(addr_i >> (5 + IDX_W));
`else
    // Upper address bits alias onto the array.
    assign w_req_oor = 1'b0;
`endif

    // Byte-offset bits (and, without range checking, upper bits) carry no meaning.
    assign w_unused_bits = ^{addr_i[4:0], addr_i[31:5+IDX_W]};

    // The edge that moves BUSY -> ACK is where the array is written or read.
    assign w_done   = (r_state == BUSY) && (r_count == 8'd1);
    assign w_mem_we = w_done && r_write && !r_oor;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE waits for a request, BUSY counts down, ACK lasts one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (enable_i) w_next = BUSY;
            BUSY:    if (r_count == 8'd1) w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request capture in IDLE and latency countdown in BUSY.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_write <= 1'b0;
            r_oor   <= 1'b0;
        end else if ((r_state == IDLE) && enable_i) begin
            r_count <= 8'(LATENCY - 1);
            r_idx   <= addr_i[5 +: IDX_W];
            r_data  <= data_i;
            r_write <= write_i;
            r_oor   <= w_req_oor;
        end else if (r_state == BUSY) begin
            r_count <= r_count - 8'd1;
        end
    end

    // Read data and error flag are loaded on the edge entering ACK.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data_o <= '0;
            r_err    <= 1'b0;
        end else if (w_done) begin
            r_err <= r_oor;
            if (!r_write) begin
                r_data_o <= r_oor ? '0 : memory[r_idx];
            end
        end else begin
            r_err <= 1'b0;
        end
    end

    // Array write, suppressed for out-of-range requests and aborted by reset via r_state.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            memory[r_idx] <= r_data;
        end
    end

    assign ack_o       = (r_state == ACK);
    assign data_o      = r_data_o;
    assign dbg_state_o = r_state;
`ifdef MEM_RANGE_CHECK_EN
    assign err_o       = r_err;
`endif

endmodule

// File: doc/line_memory_responder.md
LINE_MEMORY_RESPONDER -- requirements
Module: line_memory_responder

Interface
REQ-001 Parameter LATENCY, default 10: cycles from the request-sampling edge to the ack_o assertion edge; legal range 2..255.
REQ-002 Parameter DEPTH, default 512: number of 256-bit lines; power of two.
REQ-003 clk_i  input  1: single clock; all state changes on rising edge.
REQ-004 rst_i  input  1: reset, asynchronous, active-high.
REQ-005 addr_i  input  32: byte address; line index = addr_i[5+log2(DEPTH)-1:5]; addr_i[4:0] ignored.
REQ-006 data_i  input  256: write line data.
REQ-007 enable_i  input  1: request valid.
REQ-008 write_i  input  1: 1 = line write, 0 = line read; qualified by enable_i.
REQ-009 ack_o  output  1: one-cycle completion pulse.
REQ-010 data_o  output  256: read line data; valid while ack_o = 1.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY and ACK; the reset state is IDLE.
REQ-012 In IDLE, with enable_i = 1 at a rising edge, the block SHALL latch addr_i, data_i and write_i, load the counter with LATENCY-1 and go to BUSY; with enable_i = 0 it stays in IDLE.
REQ-013 In BUSY the counter SHALL decrement each cycle; at counter = 1 the next state SHALL be ACK.
REQ-014 ack_o SHALL be 1 exactly in ACK, i.e. LATENCY cycles after the sampling edge, for exactly one cycle.
REQ-015 Inputs SHALL be ignored in BUSY and ACK; the latched request alone is serviced.
REQ-016 Write: the latched data SHALL be stored at the latched index on the edge entering ACK; data_o SHALL hold its previous value.
REQ-017 Read: data_o SHALL be loaded from the latched index on the edge entering ACK and held until the next read completes.
REQ-018 ACK SHALL always return to IDLE; enable_i still high in the cycle after ack_o SHALL start a new request one cycle later (minimum request period LATENCY+1 cycles).
REQ-019 A read following a write to the same index SHALL return the written data.
REQ-020 Address bits above the index SHALL be ignored (aliasing/wrap-around), except as per REQ-025.

Reset
REQ-021 While rst_i = 1: state = IDLE, counter = 0, ack_o = 0, data_o = 0, latched request cleared.
REQ-022 Reset asserted mid-BUSY SHALL abort the request: no array write, no ack_o.
REQ-023 The line array SHALL NOT be cleared by reset; its contents are preloaded by the bench via hierarchical access to array name memory[0:DEPTH-1].

Configuration
REQ-024 Macro MEM_RANGE_CHECK_EN SHALL control range checking; when it is undefined, no err_o port exists and REQ-020 aliasing applies.
REQ-025 With MEM_RANGE_CHECK_EN defined: output port err_o (1 bit, reset 0) SHALL exist; a request with any addr_i bit above the index nonzero completes with normal timing, suppresses the array write, returns data_o = 0 on a read, and drives err_o = 1 in the ACK cycle only.

Verification
REQ-026 Reset, then read addr 0x0000 with memory[0] preloaded to 0x0000_1111_..._FFFF -> ack_o high exactly 10 cycles after sampling, data_o = preload value, ack_o low afterwards.
REQ-027 Write 0x0400 with data 0xA5 repeated, then read 0x0400 -> second ack_o returns 0xA5 repeated; memory[32] equals the written value.
REQ-028 enable_i held high across 3 requests -> ack_o pulses 11 cycles apart; data_i changes during BUSY are not written.
REQ-029 rst_i asserted 5 cycles into a write to 0x0020 -> no ack_o; memory[1] unchanged; next request is serviced normally.
REQ-030 With macro undefined, read 0x4000 -> returns memory[0]; with MEM_RANGE_CHECK_EN defined -> data_o = 0, err_o = 1 for one cycle, memory[0] unchanged by a write to 0x4000.
REQ-031 LATENCY = 2 -> ack_o occurs 2 cycles after sampling; back-to-back request period = 3 cycles.
